// File: rtl/board_store_if.sv
// board_store_if
//   Handshake and read-port bundle between the game controller/renderer and
//   one player's board_store.
//   lock_req/clr_req : commit / clear-board requests (sampled only when idle)
//   x1..x4, y1..y4   : the four tetromino cells (column, row; row 0 = top)
//   color            : colour code for a commit (1..7, 0 = empty)
//   raddr / rdata    : renderer read port, address = y*10 + x
//   busy, done       : engine active / one-cycle completion pulse
//   lines            : rows cleared by the last commit
//   top_out          : sticky overflow flag
interface board_store_if;
    logic       lock_req;
    logic       clr_req;
    logic [4:0] x1, x2, x3, x4;
    logic [4:0] y1, y2, y3, y4;
    logic [2:0] color;
    logic [7:0] raddr;
    logic [2:0] rdata;
    logic       busy;
    logic       done;
    logic [2:0] lines;
    logic       top_out;

    modport master (
        output lock_req, clr_req, x1, x2, x3, x4, y1, y2, y3, y4, color, raddr,
        input  rdata, busy, done, lines, top_out
    );

    modport slave (
        input  lock_req, clr_req, x1, x2, x3, x4, y1, y2, y3, y4, color, raddr,
        output rdata, busy, done, lines, top_out
    );
endinterface

// File: rtl/board_store.sv
// board_store
//   Per-player playfield store and line-clear engine. Holds a COLS x ROWS
//   board of 3-bit colour codes, serves it combinationally to the renderer,
//   commits landed tetrominoes, removes full rows with gravity compaction and
//   reports the number of rows cleared.
//   pclk : clock
//   rstn : asynchronous active-low reset (zeroes the board, aborts any op)
//   bus  : board_store_if.slave (requests, cells, colour, read port, status)
module board_store #(
    parameter int COLS      = 10,
    parameter int ROWS      = 20,
    parameter int SAFE_ROWS = 3
) (
    input logic          pclk,
    input logic          rstn,
    board_store_if.slave bus
);

    localparam int CELLS = COLS * ROWS;
    localparam int AW    = $clog2(CELLS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WRITE,
        S_SCAN,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] mem_q [CELLS];
    logic [2:0] mem_d [CELLS];
    logic [4:0] xs_q [4];
    logic [4:0] xs_d [4];
    logic [4:0] ys_q [4];
    logic [4:0] ys_d [4];
    logic [2:0] color_q, color_d;
    logic [1:0] k_q, k_d;
    logic [4:0] r_q, r_d;
    logic [4:0] i_q, i_d;
    logic [2:0] lines_q, lines_d;
    logic       top_out_q, top_out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       op_lock_q, op_lock_d;
    logic       row_full;
    logic       safe_nz;

    function automatic logic [AW-1:0] cell_idx(input logic [4:0] y, input int unsigned x);
        return AW'(int'(y) * COLS + int'(x));
    endfunction

    assign bus.rdata   = (int'(bus.raddr) < CELLS) ? mem_q[AW'(bus.raddr)] : '0;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.lines   = lines_q;
    assign bus.top_out = top_out_q;

    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            mem_q     <= '{default: '0};
            xs_q      <= '{default: '0};
            ys_q      <= '{default: '0};
            color_q   <= '0;
            k_q       <= '0;
            r_q       <= '0;
            i_q       <= '0;
            lines_q   <= '0;
            top_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_lock_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            xs_q      <= xs_d;
            ys_q      <= ys_d;
            color_q   <= color_d;
            k_q       <= k_d;
            r_q       <= r_d;
            i_q       <= i_d;
            lines_q   <= lines_d;
            top_out_q <= top_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            op_lock_q <= op_lock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        xs_d      = xs_q;
        ys_d      = ys_q;
        color_d   = color_q;
        k_d       = k_q;
        r_d       = r_q;
        i_d       = i_q;
        lines_d   = lines_q;
        top_out_d = top_out_q;
        op_lock_d = op_lock_q;
        row_full  = 1'b1;
        safe_nz   = 1'b0;

        for (int unsigned c = 0; c < COLS; c++) begin
            if (mem_q[cell_idx(r_q, c)] == '0) row_full = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.clr_req) begin
                    r_d       = '0;
                    lines_d   = '0;
                    top_out_d = 1'b0;
                    op_lock_d = 1'b0;
                    state_d   = S_CLEAR;
                end else if (bus.lock_req) begin
                    xs_d      = '{bus.x1, bus.x2, bus.x3, bus.x4};
                    ys_d      = '{bus.y1, bus.y2, bus.y3, bus.y4};
                    color_d   = bus.color;
                    lines_d   = '0;
                    k_d       = '0;
                    op_lock_d = 1'b1;
                    state_d   = S_WRITE;
                end
            end
            S_CLEAR: begin
                // r doubles as the row counter, walking top to bottom
                for (int unsigned c = 0; c < COLS; c++) mem_d[cell_idx(r_q, c)] = '0;
                if (int'(r_q) == ROWS - 1) state_d = S_DONE;
                else                       r_d     = r_q + 5'd1;
            end
            S_WRITE: begin
                if (int'(xs_q[k_q]) < COLS && int'(ys_q[k_q]) < ROWS)
                    mem_d[cell_idx(ys_q[k_q], int'(xs_q[k_q]))] = color_q;
                if (k_q == 2'd3) begin
                    r_d     = 5'(ROWS - 1);
                    state_d = S_SCAN;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_SCAN: begin
                if (row_full) begin
                    if (lines_q != 3'd7) lines_d = lines_q + 3'd1;
                    i_d     = r_q;
                    state_d = S_SHIFT;
                end else if (r_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    r_d = r_q - 5'd1;
                end
            end
            S_SHIFT: begin
                // r is left untouched so the row pulled down is re-scanned
                if (i_q == '0) begin
                    for (int unsigned c = 0; c < COLS; c++) mem_d[cell_idx(5'd0, c)] = '0;
                    state_d = S_SCAN;
                end else begin
                    for (int unsigned c = 0; c < COLS; c++)
                        mem_d[cell_idx(i_q, c)] = mem_q[cell_idx(i_q - 5'd1, c)];
                    if (i_q == 5'd1) begin
                        for (int unsigned c = 0; c < COLS; c++) mem_d[cell_idx(5'd0, c)] = '0;
                        state_d = S_SCAN;
                    end
                    i_d = i_q - 5'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int unsigned n = 0; n < SAFE_ROWS * COLS; n++) begin
            if (mem_d[AW'(n)] != '0) safe_nz = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        // evaluated on the final board so top_out rises together with done
        if (done_d && op_lock_q && safe_nz) top_out_d = 1'b1;
    end

endmodule

// File: tb/tb_board_store.sv
// tb_board_store
//   Self-checking bench for board_store. A board model applies each commit
//   as a whole (write cells, drop full rows, pad empty rows at the top) and
//   predicts the completion cycle from the rows removed; a compare process
//   checks the DUT against it every cycle, and directed tests pin the model
//   with hand-computed latencies, line counts and board images.
module tb_board_store;
    logic pclk = 1'b0;
    logic rstn = 1'b0;

    board_store_if bus ();

    board_store #(.COLS(10), .ROWS(20), .SAFE_ROWS(3)) dut (
        .pclk (pclk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [2:0] mb [20][10];
    logic [2:0] lit [256];
    int         m_t = 0;
    int         m_total = 0;
    int         m_lines = 0;
    int         m_top = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_rd(input int a);
        if (a < 200) return int'(mb[a / 10][a % 10]);
        return 0;
    endfunction

    task automatic model_zero();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) mb[r][c] = '0;
    endtask

    task automatic model_lock();
        int xs[4];
        int ys[4];
        bit full[20];
        logic [2:0] nb [20][10];
        int n;
        int extra;
        int reff;
        int dst;
        xs = '{int'(bus.x1), int'(bus.x2), int'(bus.x3), int'(bus.x4)};
        ys = '{int'(bus.y1), int'(bus.y2), int'(bus.y3), int'(bus.y4)};
        for (int k = 0; k < 4; k++)
            if (xs[k] < 10 && ys[k] < 20) mb[ys[k]][xs[k]] = bus.color;
        n = 0;
        extra = 0;
        for (int r = 19; r >= 0; r--) begin
            full[r] = 1'b1;
            for (int c = 0; c < 10; c++) if (mb[r][c] == 3'd0) full[r] = 1'b0;
            if (full[r]) begin
                // a full row is found after every full row below it has gone
                reff = r + n;
                extra += ((reff > 1) ? reff : 1) + 1;
                n++;
            end
        end
        dst = 19;
        for (int r = 19; r >= 0; r--) begin
            if (!full[r]) begin
                for (int c = 0; c < 10; c++) nb[dst][c] = mb[r][c];
                dst--;
            end
        end
        for (int r = dst; r >= 0; r--)
            for (int c = 0; c < 10; c++) nb[r][c] = '0;
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++) mb[r][c] = nb[r][c];
        m_lines = (n > 7) ? 7 : n;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 10; c++) if (mb[r][c] != 3'd0) m_top = 1;
        m_total = 25 + extra;
    endtask

    initial begin
        model_zero();
        forever begin
            @(posedge pclk or negedge rstn);
            if (!rstn) begin
                model_zero();
                m_t = 0;
                m_total = 0;
                m_lines = 0;
                m_top = 0;
            end else if (m_t == 0) begin
                if (bus.clr_req) begin
                    model_zero();
                    m_lines = 0;
                    m_top = 0;
                    m_total = 21;
                    m_t = 1;
                end else if (bus.lock_req) begin
                    model_lock();
                    m_t = 1;
                end
            end else if (m_t == m_total) begin
                m_t = 0;
            end else begin
                m_t++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge pclk);
            if (chk_en) begin
                check("busy", int'(bus.busy), (m_t != 0) ? 1 : 0);
                check("done", int'(bus.done), (m_t != 0 && m_t == m_total) ? 1 : 0);
                if (m_t == 0 || m_t == m_total) begin
                    check("lines", int'(bus.lines), m_lines);
                    check("top_out", int'(bus.top_out), m_top);
                    check("rdata", int'(bus.rdata), model_rd(int'(bus.raddr)));
                end
            end
        end
    end

    task automatic launch(input bit lk, input bit cl,
                          input int ax1, input int ay1, input int ax2, input int ay2,
                          input int ax3, input int ay3, input int ax4, input int ay4,
                          input int col);
        @(posedge pclk);
        #1;
        bus.lock_req = lk;
        bus.clr_req  = cl;
        bus.x1 = 5'(ax1); bus.y1 = 5'(ay1);
        bus.x2 = 5'(ax2); bus.y2 = 5'(ay2);
        bus.x3 = 5'(ax3); bus.y3 = 5'(ay3);
        bus.x4 = 5'(ax4); bus.y4 = 5'(ay4);
        bus.color = 3'(col);
        @(posedge pclk);
        #1;
        bus.lock_req = 1'b0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus.done && lat < 400) begin
            @(posedge pclk);
            #1;
            lat++;
        end
        if (!bus.done) check("done_timeout", 0, 1);
        @(posedge pclk);
        #1;
    endtask

    task automatic lock_op(input int ax1, input int ay1, input int ax2, input int ay2,
                           input int ax3, input int ay3, input int ax4, input int ay4,
                           input int col, output int lat);
        launch(1'b1, 1'b0, ax1, ay1, ax2, ay2, ax3, ay3, ax4, ay4, col);
        wait_done(lat);
    endtask

    task automatic clear_op(output int lat);
        launch(1'b0, 1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_done(lat);
    endtask

    task automatic lit_zero();
        for (int a = 0; a < 256; a++) lit[a] = '0;
    endtask

    task automatic sweep(input string nm);
        for (int a = 0; a < 256; a++) begin
            @(posedge pclk);
            #1;
            bus.raddr = 8'(a);
            #1;
            check(nm, int'(bus.rdata), int'(lit[a]));
        end
    endtask

    initial begin
        int lat;
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.lock_req = 1'b0;
        bus.clr_req  = 1'b0;
        bus.x1 = '0; bus.x2 = '0; bus.x3 = '0; bus.x4 = '0;
        bus.y1 = '0; bus.y2 = '0; bus.y3 = '0; bus.y4 = '0;
        bus.color = '0;
        bus.raddr = '0;

        @(posedge pclk);
        #1;
        chk_en = 1'b1;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_lines", int'(bus.lines), 0);
        check("rst_top_out", int'(bus.top_out), 0);
        repeat (2) @(posedge pclk);
        #1;
        rstn = 1'b1;

        lit_zero();
        sweep("rst_sweep");

        // bottom-row I piece, no full rows
        lock_op(0, 19, 1, 19, 2, 19, 3, 19, 1, lat);
        check("t2_latency", lat, 25);
        check("t2_lines", int'(bus.lines), 0);
        lit_zero();
        for (int a = 190; a <= 193; a++) lit[a] = 3'd1;
        sweep("t2_sweep");

        clear_op(lat);
        check("clr_latency", lat, 21);

        // single line clear with a row above that drops down
        lock_op(0, 19, 1, 19, 2, 19, 3, 19, 2, lat);
        lock_op(4, 19, 5, 19, 5, 19, 5, 19, 2, lat);
        lock_op(0, 18, 0, 18, 0, 18, 0, 18, 5, lat);
        lock_op(6, 19, 7, 19, 8, 19, 9, 19, 3, lat);
        check("t3_latency", lat, 45);
        check("t3_lines", int'(bus.lines), 1);
        lit_zero();
        lit[190] = 3'd5;
        sweep("t3_sweep");

        clear_op(lat);

        // four rows missing column 9, then a vertical I fills them
        for (int p = 0; p < 9; p++) begin
            int q;
            q = p * 4;
            lock_op(q % 9, 16 + q / 9, (q + 1) % 9, 16 + (q + 1) / 9,
                    (q + 2) % 9, 16 + (q + 2) / 9, (q + 3) % 9, 16 + (q + 3) / 9,
                    1 + (p % 7), lat);
        end
        lock_op(9, 16, 9, 17, 9, 18, 9, 19, 4, lat);
        check("t4_latency", lat, 105);
        check("t4_lines", int'(bus.lines), 4);
        lit_zero();
        sweep("t4_sweep");

        // out-of-range column is dropped, not aliased onto another cell
        lock_op(12, 5, 0, 10, 1, 10, 2, 10, 6, lat);
        check("t5_latency", lat, 25);
        check("t5_lines", int'(bus.lines), 0);
        lit_zero();
        for (int a = 100; a <= 102; a++) lit[a] = 3'd6;
        sweep("t5_sweep");

        // top-out, then clear beats a simultaneous lock
        lock_op(4, 1, 4, 1, 4, 1, 4, 1, 7, lat);
        check("t6_top_out", int'(bus.top_out), 1);
        launch(1'b1, 1'b1, 0, 19, 1, 19, 2, 19, 3, 19, 1);
        wait_done(lat);
        check("t6_clr_latency", lat, 21);
        check("t6_top_out_clr", int'(bus.top_out), 0);
        check("t6_lines_clr", int'(bus.lines), 0);
        lit_zero();
        sweep("t6_sweep");

        // reset while the engine is shifting rows down
        lock_op(0, 19, 1, 19, 2, 19, 3, 19, 1, lat);
        lock_op(4, 19, 5, 19, 6, 19, 7, 19, 2, lat);
        launch(1'b1, 1'b0, 8, 19, 9, 19, 5, 18, 5, 18, 3);
        repeat (9) @(posedge pclk);
        #1;
        check("t7_busy_pre", int'(bus.busy), 1);
        rstn = 1'b0;
        #1;
        check("t7_busy_rst", int'(bus.busy), 0);
        check("t7_done_rst", int'(bus.done), 0);
        @(posedge pclk);
        #1;
        rstn = 1'b1;
        check("t7_lines", int'(bus.lines), 0);
        check("t7_top_out", int'(bus.top_out), 0);
        lit_zero();
        sweep("t7_sweep");

        repeat (2) @(posedge pclk);
        #1;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
